// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the DMG timer: register map, FSM states, TAC decode.
package dmg_timer_pkg;

  // CPU register select values (FF04..FF07 low bits)
  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  // Unused TAC bits always read back as ones
  localparam logic [7:0] TAC_READ_MASK = 8'hF8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OVF_PEND = 2'd1,
    RELOAD   = 2'd2
  } timer_state_t;

  // Counter bit watched by the timer for each TAC clock-select value
  function automatic logic [3:0] tac_tap_index(input logic [1:0] sel);
    logic [3:0] idx;
    case (sel)
      2'b00:   idx = 4'd9;
      2'b01:   idx = 4'd3;
      2'b10:   idx = 4'd5;
      default: idx = 4'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/dmg_timer_tick_gen.sv
// Tick generator: falling edge of (enable & selected counter tap).
// Because the edge is taken on the gated signal, clearing the counter,
// dropping the enable or switching the tap can all produce a tick.
module timer_tick_gen
  import dmg_timer_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] counter,
  input  logic [2:0]  tac,
  output logic        tick
);

  logic sig;
  logic sig_d;

  // Gated tap selected by TAC
  always_comb begin
    sig = tac[2] & counter[tac_tap_index(tac[1:0])];
  end

  // Remember last cycle's gated tap for edge detection
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) sig_d <= 1'b0;
    else        sig_d <= sig;
  end

  assign tick = sig_d & ~sig;

endmodule

// File: rtl/dmg_timer.sv
// DMG timer: DIV system counter, TIMA/TMA/TAC registers, delayed TMA
// reload on TIMA overflow and the timer interrupt request pulse.
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter logic [15:0] DIV_INIT     = 16'h0000,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tima_load,
  output logic [7:0] tima_q,
  output logic       irq_timer
);

  localparam int DW = $clog2(RELOAD_DELAY + 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(RELOAD_DELAY - 1);

  logic [15:0]    counter;
  logic [7:0]     tima;
  logic [7:0]     tma;
  logic [2:0]     tac;
  timer_state_t   state;
  logic [DW-1:0]  delay_cnt;
  logic           tick;

  logic wr_div;
  logic wr_tima;
  logic wr_tma;
  logic wr_tac;

  // Register write decode
  always_comb begin
    wr_div  = wr && (addr == ADDR_DIV);
    wr_tima = wr && (addr == ADDR_TIMA);
    wr_tma  = wr && (addr == ADDR_TMA);
    wr_tac  = wr && (addr == ADDR_TAC);
  end

  // Free-running system counter; any DIV write clears it
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset)      counter <= DIV_INIT;
    else if (wr_div) counter <= 16'h0000;
    else             counter <= counter + 16'd1;
  end

  // TMA and TAC configuration registers
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];
    end
  end

  timer_tick_gen u_tick_gen (
    .clk     (clk),
    .nreset  (nreset),
    .counter (counter),
    .tac     (tac),
    .tick    (tick)
  );

  // TIMA counting, overflow delay and reload FSM with registered pulses
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state     <= IDLE;
      tima      <= 8'h00;
      delay_cnt <= '0;
      irq_timer <= 1'b0;
      tima_load <= 1'b0;
    end else begin
      irq_timer <= 1'b0;
      tima_load <= 1'b0;
      case (state)
        IDLE: begin
          // A CPU write beats a coincident tick
          if (wr_tima) begin
            tima      <= wdata;
            tima_load <= 1'b1;
          end else if (tick) begin
            if (tima == 8'hFF) begin
              tima      <= 8'h00;
              delay_cnt <= '0;
              state     <= OVF_PEND;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        OVF_PEND: begin
          // TIMA sits at zero; a CPU write here cancels the reload and irq
          if (wr_tima) begin
            tima      <= wdata;
            tima_load <= 1'b1;
            state     <= IDLE;
          end else if (delay_cnt == DELAY_LAST) begin
            tima      <= tma;
            tima_load <= 1'b1;
            irq_timer <= 1'b1;
            state     <= RELOAD;
          end else begin
            delay_cnt <= delay_cnt + DW'(1);
          end
        end
        RELOAD: begin
          // TIMA writes are dropped; a TMA write passes straight into TIMA,
          // which is a fresh load so the set/reset drivers are pulsed again
          state <= IDLE;
          if (wr_tma) begin
            tima      <= wdata;
            tima_load <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tima_q = tima;

  // Combinational register readback
  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_DIV:  rdata = counter[15:8];
      ADDR_TIMA: rdata = tima;
      ADDR_TMA:  rdata = tma;
      default:   rdata = TAC_READ_MASK | {5'b00000, tac};
    endcase
  end

endmodule

// File: tb/tb_dmg_timer.sv
// Directed bench for dmg_timer with an expected-value scoreboard queue.
module tb_dmg_timer;
  import dmg_timer_pkg::*;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [1:0] addr = 2'd0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       tima_load;
  logic [7:0] tima_q;
  logic       irq_timer;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  dmg_timer #(.DIV_INIT(16'h0000), .RELOAD_DELAY(4)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .addr      (addr),
    .wr        (wr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tima_load (tima_load),
    .tima_q    (tima_q),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick(1);
    wr    = 1'b0;
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %02h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      $display("[%0t] check %s observed=%02h expected=%02h", $time, e.tag, obs, e.val);
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %02h required %02h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_tima(input string tag, input logic [7:0] v);
    push(tag, v);
    pop_check(tima_q);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic v);
    push(tag, {7'b0, v});
    pop_check({7'b0, obs});
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] v);
    push(tag, v);
    addr = a;
    #1;
    pop_check(rdata);
  endtask

  // Wait (bounded) for TIMA to leave FF, then expect the overflow value 00
  task automatic wait_ovf(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (tima_q !== 8'hFF) break;
    end
    chk_tima(tag, 8'h00);
  endtask

  initial begin
    logic irq_seen;

    // Reset state
    tick(3);
    chk_tima("rst_tima", 8'h00);
    chk_bit("rst_irq", irq_timer, 1'b0);
    chk_bit("rst_load", tima_load, 1'b0);
    chk_reg("rst_div", ADDR_DIV, 8'h00);
    chk_reg("rst_tac", ADDR_TAC, 8'hF8);

    // Count rate: TAC=101 written on the first edge after release
    nreset = 1'b0;
    addr   = ADDR_TAC;
    wdata  = 8'h05;
    wr     = 1'b1;
    tick(1);
    wr     = 1'b0;
    push("rate_tima_159", 8'h09);
    tick(159);
    pop_check(tima_q);
    push("rate_tima_160", 8'h0A);
    tick(1);
    pop_check(tima_q);
    chk_reg("rate_div_161", ADDR_DIV, 8'h00);
    tick(94);
    chk_reg("rate_div_255", ADDR_DIV, 8'h00);
    tick(1);
    chk_reg("rate_div_256", ADDR_DIV, 8'h01);
    chk_tima("rate_tima_256", 8'h0F);

    // Overflow and delayed reload
    wr_reg(ADDR_TMA, 8'hF0);
    wr_reg(ADDR_TIMA, 8'hFF);
    wait_ovf("ovf_e0");
    for (int k = 1; k < 4; k++) begin
      tick(1);
      chk_tima("ovf_pend_tima", 8'h00);
      chk_bit("ovf_pend_irq", irq_timer, 1'b0);
    end
    tick(1);
    chk_tima("ovf_reload_tima", 8'hF0);
    chk_bit("ovf_reload_irq", irq_timer, 1'b1);
    chk_bit("ovf_reload_load", tima_load, 1'b1);
    tick(1);
    chk_bit("ovf_after_irq", irq_timer, 1'b0);
    chk_bit("ovf_after_load", tima_load, 1'b0);
    chk_tima("ovf_after_tima", 8'hF0);

    // Cancel reload by TIMA write two clks after overflow
    wr_reg(ADDR_TIMA, 8'hFF);
    wait_ovf("cancel_e0");
    tick(1);
    wr_reg(ADDR_TIMA, 8'h33);
    chk_tima("cancel_tima", 8'h33);
    chk_bit("cancel_load", tima_load, 1'b1);
    irq_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      irq_seen = irq_seen | irq_timer;
    end
    chk_bit("cancel_no_irq", irq_seen, 1'b0);
    chk_tima("cancel_tima_hold", 8'h33);

    // Glitch tick from DIV write while counter[3]=1
    wr_reg(ADDR_DIV, 8'h00);
    tick(7);
    wr_reg(ADDR_TIMA, 8'h40);
    tick(1);
    chk_tima("gdiv_base", 8'h40);
    wr_reg(ADDR_DIV, 8'hA5);
    chk_reg("gdiv_div_clr", ADDR_DIV, 8'h00);
    chk_tima("gdiv_pre", 8'h40);
    tick(1);
    chk_tima("gdiv_inc", 8'h41);
    tick(3);
    chk_tima("gdiv_once", 8'h41);

    // Glitch tick from TAC 101 -> 001 while counter[3]=1
    tick(4);
    wr_reg(ADDR_TIMA, 8'h80);
    chk_tima("gtac_base", 8'h80);
    wr_reg(ADDR_TAC, 8'h01);
    chk_tima("gtac_pre", 8'h80);
    tick(1);
    chk_tima("gtac_inc", 8'h81);
    chk_reg("gtac_tac_rd", ADDR_TAC, 8'hF9);
    tick(8);
    chk_tima("gtac_disabled", 8'h81);

    // TMA write during the reload clk lands in TIMA too
    wr_reg(ADDR_TAC, 8'h05);
    wr_reg(ADDR_TIMA, 8'hFF);
    wait_ovf("rl_tma_e0");
    tick(4);
    chk_bit("rl_tma_irq", irq_timer, 1'b1);
    wr_reg(ADDR_TMA, 8'h55);
    chk_tima("rl_tma_tima", 8'h55);
    chk_reg("rl_tma_reg", ADDR_TMA, 8'h55);

    // TIMA write during the reload clk is ignored
    wr_reg(ADDR_TIMA, 8'hFF);
    wait_ovf("rl_tima_e0");
    tick(4);
    chk_tima("rl_tima_reload", 8'h55);
    wr_reg(ADDR_TIMA, 8'h77);
    chk_tima("rl_tima_ignored", 8'h55);

    // Asynchronous reset in the middle of the overflow delay
    wr_reg(ADDR_TIMA, 8'hFF);
    wait_ovf("arst_e0");
    tick(1);
    #2;
    nreset = 1'b1;
    #1;
    chk_tima("arst_tima", 8'h00);
    chk_bit("arst_irq", irq_timer, 1'b0);
    chk_bit("arst_load", tima_load, 1'b0);
    chk_reg("arst_tma", ADDR_TMA, 8'h00);
    chk_reg("arst_tac", ADDR_TAC, 8'hF8);
    chk_reg("arst_div", ADDR_DIV, 8'h00);
    tick(2);
    nreset = 1'b0;
    irq_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      irq_seen = irq_seen | irq_timer;
    end
    chk_bit("arst_no_irq", irq_seen, 1'b0);
    chk_tima("arst_tima_idle", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmg_timer.md
Name: dmg_timer

Overview:
- DMG timer block: free-running 16-bit system counter (DIV), TIMA/TMA/TAC registers and timer interrupt request.
- Produces the TIMA load value and the overflow reload pulse. These drive the asynchronous set/reset inputs of the downstream TIMA storage flops in the gate-level netlist.
- Sits between the CPU register bus (FF04–FF07) and the interrupt controller (IF bit 2).

Parameters:
- DIV_INIT, 16'h0000, value of the internal 16-bit counter after reset.
- RELOAD_DELAY, 4, clk cycles between TIMA overflow and the TMA reload/irq.

Ports:
- clk  input  1  system clock, 4.194304 MHz T-cycle clock.
- nreset  input  1  reset, asynchronous, active-high.
- addr  input  2  register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- wr  input  1  write strobe, sampled on rising clk.
- wdata  input  8  write data.
- rdata  output  8  read data for addr, combinational.
- tima_load  output  1  one-clk pulse when TIMA is loaded (by CPU write or by reload); for the set/reset cell drivers.
- tima_q  output  8  current TIMA value.
- irq_timer  output  1  one-clk interrupt request pulse to IF bit 2.

Behaviour:
- Reset values while nreset=1:
  - counter=DIV_INIT, TIMA=0, TMA=0, TAC=0.
  - irq_timer=0, tima_load=0, state=IDLE.
  - These values are applied asynchronously and override everything else.
- Counter:
  - Increments by 1 every clk and wraps 16'hFFFF -> 0.
  - Read of DIV returns counter[15:8].
  - Write to DIV (any data) clears the counter to 0 on that edge.
- TAC:
  - Only bits [2:0] are stored; reads return {5'b11111, TAC[2:0]}.
  - TAC[2] is the timer enable. TAC[1:0] selects the tap: 00 -> counter[9], 01 -> counter[3], 10 -> counter[5], 11 -> counter[7].
- Tick:
  - sig = TAC[2] & selected tap, registered each clk into sig_d.
  - Tick = sig_d & !sig, a falling edge.
  - A falling edge caused by a DIV write, a TAC enable clear or a TAC select change also counts as a tick. This is the hardware glitch and is required.
- TIMA increments by 1 on tick; 8'hFF + 1 -> 8'h00 and enters OVF_PEND.
- State machine:
  - IDLE: normal counting.
  - OVF_PEND: TIMA reads 8'h00 for RELOAD_DELAY clks; ticks during this state are ignored.
    - CPU write to TIMA here: TIMA takes wdata, tima_load pulses, return to IDLE. Reload and irq are cancelled.
    - Otherwise, after RELOAD_DELAY clks, go to RELOAD.
  - RELOAD: one clk. TIMA takes TMA, tima_load=1, irq_timer=1, then IDLE.
    - CPU write to TIMA in RELOAD is ignored.
    - CPU write to TMA in RELOAD: the new value is loaded into both TMA and TIMA that edge.
- Writes:
  - A CPU TIMA write in IDLE loads wdata and pulses tima_load.
  - A tick coinciding with that write is lost; the write wins.
- rdata: combinational mux on addr, no latency.
- irq_timer and tima_load are registered outputs, exactly one clk wide.
- Reset asserted mid-operation (e.g. in OVF_PEND):
  - Aborts immediately.
  - No irq is produced after deassert.
  - State returns to IDLE.

Decomposition:
- Package dmg_timer_pkg holds:
  - register address constants DIV/TIMA/TMA/TAC;
  - timer_state_t enum {IDLE, OVF_PEND, RELOAD};
  - the TAC tap-index lookup function;
  - the TAC readback mask 8'hF8.
- One sub-module, timer_tick_gen, contains the tap mux, the sig_d register and the falling-edge detect. Its inputs are counter, TAC[2:0], clk and nreset; its output is tick.

Test Plan:
- Count rate: reset, TAC=3'b101 (bit3 tap), wait 160 clks -> TIMA=8'h0A, DIV reads 8'h00; at clk 256, DIV=8'h01.
- Overflow/reload:
  - Setup: TMA=8'hF0, TIMA=8'hFF, TAC=3'b101; run to the next tick.
  - TIMA=8'h00 for 4 clks.
  - Then TIMA=8'hF0, with irq_timer and tima_load high for exactly 1 clk on the same cycle.
- Cancel: overflow as above, write TIMA=8'h33 two clks after overflow -> TIMA=8'h33, no irq_timer, state IDLE.
- Glitch ticks:
  - TAC=3'b101, run until counter[3]=1, write DIV -> TIMA increments by exactly 1 and counter=0.
  - Repeat with TAC write 3'b101 -> 3'b001 -> TIMA increments by 1.
- Reload-cycle write: in the RELOAD clk, write TMA=8'h55 -> TIMA=8'h55. In a separate run, writing TIMA=8'h77 in RELOAD -> TIMA=TMA, write ignored.
- Async reset mid-OVF_PEND: assert nreset between clk edges -> all outputs 0 immediately, no irq after release, TAC reads 8'hF8.
